// File: rtl/timer.sv
// timer: 16-bit prescaled down-counter on the I/O bus with a registered level interrupt.
// Define TIMER_WDOG_EN to add the sticky watchdog bit and the 16-clock wdog_reset pulse.
module timer #(
    parameter int unsigned RV  = 16,
    parameter int unsigned PSW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    io_addr,
    input  logic          io_write,
    input  logic          io_read,
    input  logic [RV-1:0] io_wdata,
    output logic [RV-1:0] io_rdata,
    output logic          interrupt
`ifdef TIMER_WDOG_EN
    ,
    output logic          wdog_reset
`endif
);

    logic [RV-1:0]  count;
    logic [RV-1:0]  reload;
    logic [PSW-1:0] prescale;
    logic [PSW-1:0] pcnt;
    logic           en;
    logic           auto_reload;
    logic           irq_en;
    logic           wdog;
    logic           expired;

    logic wr_count, wr_reload, wr_prescale, wr_ctrl, wr_status;
    logic tick, tick_eff, expire;

    // Status reads have no side effect; the strobe is accepted but unused.
    logic unused_read;
    assign unused_read = io_read;

    assign wr_count    = io_write && (io_addr == 4'd0);
    assign wr_reload   = io_write && (io_addr == 4'd1);
    assign wr_prescale = io_write && (io_addr == 4'd2);
    assign wr_ctrl     = io_write && (io_addr == 4'd3);
    assign wr_status   = io_write && (io_addr == 4'd4);

    assign tick     = en && (pcnt == prescale);
    // A COUNT write swallows a coincident tick, including its expiry.
    assign tick_eff = tick && !wr_count;
    assign expire   = tick_eff && (count == '0);

    // pcnt sits at 0 whenever en=0, so an enabling CTRL write always starts a fresh period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= io_wdata;
        end else if (tick_eff) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end else if (auto_reload) begin
                count <= reload;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload   <= '0;
            prescale <= '0;
        end else begin
            if (wr_reload) begin
                reload <= io_wdata;
            end
            if (wr_prescale) begin
                prescale <= io_wdata[PSW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
        end else if (wr_ctrl) begin
            en          <= io_wdata[0];
            auto_reload <= io_wdata[1];
            irq_en      <= io_wdata[2];
        end else if (expire && !auto_reload) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expired   <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (expire) begin
                expired <= 1'b1;
            end else if (wr_status && io_wdata[0]) begin
                expired <= 1'b0;
            end
            interrupt <= expired & irq_en;
        end
    end

`ifdef TIMER_WDOG_EN
    logic       expire_q;
    logic [3:0] wdog_cnt;

    // Pulse starts one cycle after expired sets and runs a fixed 16 clocks; retriggers are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog       <= 1'b0;
            expire_q   <= 1'b0;
            wdog_cnt   <= '0;
            wdog_reset <= 1'b0;
        end else begin
            if (wr_ctrl && io_wdata[3]) begin
                wdog <= 1'b1;
            end
            expire_q <= expire && wdog;
            if (wdog_reset) begin
                wdog_cnt <= wdog_cnt + 1'b1;
                if (wdog_cnt == 4'hf) begin
                    wdog_reset <= 1'b0;
                end
            end else if (expire_q) begin
                wdog_reset <= 1'b1;
                wdog_cnt   <= '0;
            end
        end
    end
`else
    assign wdog = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            4'd0:    io_rdata = count;
            4'd1:    io_rdata = reload;
            4'd2:    io_rdata[PSW-1:0] = prescale;
            4'd3:    io_rdata[3:0] = {wdog, irq_en, auto_reload, en};
            4'd4:    io_rdata[0] = expired;
            default: io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer.sv
// tb_timer: scoreboard bench for timer; reads queue expected data, a negedge monitor compares.
module tb_timer;
    localparam int unsigned RV  = 16;
    localparam int unsigned PSW = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [3:0]    io_addr  = '0;
    logic          io_write = 1'b0;
    logic          io_read  = 1'b0;
    logic [RV-1:0] io_wdata = '0;
    logic [RV-1:0] io_rdata;
    logic          interrupt;
`ifdef TIMER_WDOG_EN
    logic          wdog_reset;
`endif

    timer #(.RV(RV), .PSW(PSW)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_addr   (io_addr),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .interrupt (interrupt)
`ifdef TIMER_WDOG_EN
        ,
        .wdog_reset(wdog_reset)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] data;
        bit          chk_intr;
        bit          intr;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;
    int unsigned edges  = 0;

    always @(posedge clk) edges <= edges + 1;

    // Monitor: every cycle with io_read high presents a response to be scored.
    always @(negedge clk) begin
        if (io_read) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: rdata=%h with no queued expectation", io_rdata);
            end else begin
                cur = sb.pop_front();
                checks++;
                if (io_rdata !== cur.data) begin
                    errors++;
                    $display("FAIL %s: rdata=%h required %h", cur.name, io_rdata, cur.data);
                end
                if (cur.chk_intr) begin
                    checks++;
                    if (interrupt !== cur.intr) begin
                        errors++;
                        $display("FAIL %s_intr: interrupt=%b required %b", cur.name, interrupt, cur.intr);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        io_write = 1'b1;
        io_addr  = a;
        io_wdata = d;
        step();
        io_write = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input string n, input bit ci, input bit iv);
        exp_t e;
        e.name     = n;
        e.data     = d;
        e.chk_intr = ci;
        e.intr     = iv;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] d, input string n,
                      input bit ci, input bit iv);
        push(d, n, ci, iv);
        io_read = 1'b1;
        io_addr = a;
        step();
        io_read = 1'b0;
    endtask

    task automatic wait_to(input int unsigned e0, input int unsigned n);
        while (edges - e0 < n) step();
        if (edges - e0 != n) begin
            errors++;
            $display("FAIL schedule: at N=%0d required N=%0d", edges - e0, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Closed-form reference: state after n clocks from the enabling edge.
    // Tick k lands at clock k*(p+1); ticks 1..c0 count down, tick c0+1 expires,
    // then auto-reload repeats with period r+1 ticks, one-shot goes idle.
    function automatic void model(input int c0, input int r, input int p, input bit ar,
                                  input int n, output int cnt, output bit ex, output bit en);
        int ticks;
        ticks = n / (p + 1);
        if (ticks <= c0) begin
            cnt = c0 - ticks;
            ex  = 1'b0;
            en  = 1'b1;
        end else if (!ar) begin
            cnt = 0;
            ex  = 1'b1;
            en  = 1'b0;
        end else begin
            cnt = r - ((ticks - c0 - 1) % (r + 1));
            ex  = 1'b1;
            en  = 1'b1;
        end
    endfunction

    task automatic check_model(input int unsigned e0, input int c0, input int r, input int p,
                               input bit ar, input bit irq);
        int cnt, cp, n;
        bit ex, en, exp_prev, enp;
        for (int k = 0; k < 3; k++) begin
            n = int'(edges - e0);
            model(c0, r, p, ar, n, cnt, ex, en);
            if (n == 0) exp_prev = 1'b0;
            else        model(c0, r, p, ar, n - 1, cp, exp_prev, enp);
            case (k)
                0: rd(4'd0, cnt[15:0], "rnd_count", 1'b1, exp_prev & irq);
                1: rd(4'd4, {15'd0, ex}, "rnd_status", 1'b1, exp_prev & irq);
                default: rd(4'd3, {13'd0, irq, ar, en}, "rnd_ctrl", 1'b1, exp_prev & irq);
            endcase
        end
    endtask

    initial begin
        int unsigned e0;
        int c0, r, p, w;
        bit ar, irq;
        int cnt;
        bit ex, en;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        for (int a = 0; a < 5; a++) rd(4'(a), 16'h0000, "reset_read", 1'b1, 1'b0);

        // Periodic: PRESCALE=3, RELOAD=4, COUNT=4, CTRL=en|auto|irq
        wr(4'd2, 16'd3);
        wr(4'd1, 16'd4);
        wr(4'd0, 16'd4);
        e0 = edges + 1;
        wr(4'd3, 16'h0007);
        wait_to(e0, 10);
        model(4, 4, 3, 1'b1, 10, cnt, ex, en);
        rd(4'd0, cnt[15:0], "per_count_mid", 1'b0, 1'b0);
        wait_to(e0, 19);
        rd(4'd4, 16'h0000, "per_status_19", 1'b1, 1'b0);
        rd(4'd4, 16'h0001, "per_status_20", 1'b1, 1'b0);
        rd(4'd4, 16'h0001, "per_status_21", 1'b1, 1'b1);
        wr(4'd4, 16'h0001);
        rd(4'd4, 16'h0000, "per_clear_23", 1'b1, 1'b1);
        rd(4'd4, 16'h0000, "per_clear_24", 1'b1, 1'b0);
        wait_to(e0, 39);
        rd(4'd4, 16'h0000, "per_status_39", 1'b1, 1'b0);
        rd(4'd4, 16'h0001, "per_status_40", 1'b1, 1'b0);
        wr(4'd1, 16'd9);
        rd(4'd0, 16'd4, "per_reload_no_effect", 1'b0, 1'b0);
        rd(4'd1, 16'd9, "per_reload_read", 1'b0, 1'b0);

        // One-shot: PRESCALE=0, COUNT=2, CTRL=en|irq
        do_reset();
        wr(4'd2, 16'd0);
        wr(4'd0, 16'd2);
        e0 = edges + 1;
        wr(4'd3, 16'h0005);
        wait_to(e0, 2);
        rd(4'd4, 16'h0000, "os_status_2", 1'b0, 1'b0);
        rd(4'd4, 16'h0001, "os_status_3", 1'b0, 1'b0);
        rd(4'd3, 16'h0004, "os_ctrl", 1'b1, 1'b1);
        rd(4'd0, 16'h0000, "os_count", 1'b0, 1'b0);
        wr(4'd4, 16'h0001);
        repeat (100) step();
        rd(4'd4, 16'h0000, "os_no_reexpire", 1'b1, 1'b0);
        rd(4'd0, 16'h0000, "os_count_idle", 1'b0, 1'b0);

        // Collision: STATUS clear lands on the expiry edge
        do_reset();
        wr(4'd0, 16'd2);
        e0 = edges + 1;
        wr(4'd3, 16'h0005);
        wait_to(e0, 2);
        wr(4'd4, 16'h0001);
        rd(4'd4, 16'h0001, "col_status_set_wins", 1'b0, 1'b0);

        // Collision: COUNT write lands on a tick
        do_reset();
        wr(4'd0, 16'd5);
        e0 = edges + 1;
        wr(4'd3, 16'h0001);
        wait_to(e0, 1);
        wr(4'd0, 16'h1234);
        rd(4'd0, 16'h1234, "col_count_write_wins", 1'b0, 1'b0);
        rd(4'd0, 16'h1233, "col_count_after", 1'b0, 1'b0);

        // Mid-count asynchronous reset
        do_reset();
        wr(4'd0, 16'h0800);
        e0 = edges + 1;
        wr(4'd3, 16'h0001);
        wait_to(e0, 5);
        rd(4'd0, 16'h07FB, "mid_count_running", 1'b0, 1'b0);
        push(16'h0000, "mid_rst_count", 1'b1, 1'b0);
        io_read = 1'b1;
        io_addr = 4'd0;
        #2 reset = 1'b1;
        step();
        io_read = 1'b0;
        rd(4'd3, 16'h0000, "mid_rst_ctrl", 1'b0, 1'b0);
        reset = 1'b0;

        // Randomized configurations against the closed-form model
        for (int t = 0; t < 12; t++) begin
            do_reset();
            p   = int'($urandom_range(3, 0));
            r   = int'($urandom_range(5, 0));
            c0  = int'($urandom_range(6, 0));
            ar  = 1'($urandom_range(1, 0));
            irq = 1'($urandom_range(1, 0));
            w   = int'($urandom_range(45, 0));
            wr(4'd2, 16'(p));
            wr(4'd1, 16'(r));
            wr(4'd0, 16'(c0));
            e0 = edges + 1;
            wr(4'd3, {13'd0, irq, ar, 1'b1});
            repeat (w) step();
            check_model(e0, c0, r, p, ar, irq);
        end

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- 16-bit programmable down-counter peripheral on the CPU I/O bus, decoded at I/O window addr[8:5]==3.
- Produces a level interrupt that feeds the `intr` interrupt controller as a new source alongside the uart, spi and gpio sources.
- Gives the core a periodic tick / one-shot timeout, scaled from clk by a programmable prescaler.

Parameters:
- RV, 16, register/data width; counter and reload width.
- PSW, 8, prescaler register width in bits.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_addr  input  4  register select, driven from addr[4:1].
- io_write  input  1  write strobe; already qualified by io_access, !fault and window decode.
- io_read  input  1  read strobe, qualified the same way; used only for the status read side effect (none defined, reserved).
- io_wdata  input  RV  write data.
- io_rdata  output  RV  combinational read data for io_addr.
- interrupt  output  1  registered, level-sensitive; high while expired && irq_en.
- wdog_reset  output  1  present only with TIMER_WDOG_EN; see Optional Feature.

Behaviour:
Register map (io_addr; unlisted addresses read 0, writes ignored):
- 0 COUNT: R/W; a write loads the counter.
- 1 RELOAD: R/W.
- 2 PRESCALE: R/W, bits [PSW-1:0]; upper bits read 0.
- 3 CTRL: R/W.
  - bit0 en
  - bit1 auto_reload
  - bit2 irq_en
  - bit3 wdog (reads 0 without the macro)
  - other bits read 0.
- 4 STATUS: bit0 expired; write 1 to clear, write 0 has no effect.

Reset values:
- count, reload, prescale, ctrl, expired, prescaler counter: all 0.
- interrupt: 0.
- io_rdata reflects the zeroed registers.

Prescaler:
- Internal counter pcnt[PSW-1:0] runs only while en=1.
- tick is asserted in a cycle when pcnt==PRESCALE; pcnt then returns to 0, otherwise it increments.
- Result: one tick every PRESCALE+1 clocks (PRESCALE=0 gives a tick every clock).
- pcnt is held at 0 while en=0.
- A CTRL write that takes en from 0 to 1 forces pcnt=0 that cycle.

On each tick:
- If count!=0: count <= count-1.
- If count==0:
  - expired <= 1.
  - If auto_reload: count <= RELOAD.
  - Else (one-shot): en <= 0 and count stays 0.
- Expiry therefore occurs (count+1)*(PRESCALE+1) clocks after enable, measured from the rising edge at which the enabling CTRL write is captured.

Interrupt:
- interrupt <= expired & irq_en, registered.
- It is visible one cycle after expired or irq_en changes.

Simultaneous events:
- COUNT write and tick in the same cycle: the write wins; the tick is lost; pcnt still advances normally.
- STATUS clear and expiry in the same cycle: set wins, expired stays 1.
- CTRL write and one-shot auto-clear of en in the same cycle: the CTRL write wins.
- Writing RELOAD does not affect the running count.

Widths and reset:
- count wrap-around never occurs: decrement only when count!=0.
- Reset asserted mid-count returns every register to its reset value immediately (asynchronous).

Optional Feature:
- Macro: TIMER_WDOG_EN.
- With the macro defined:
  - CTRL bit3 (wdog) is sticky: once written 1 it can only be cleared by reset.
  - While wdog=1, any expiry drives wdog_reset high for exactly 16 consecutive clocks, starting the cycle after expired sets, using an internal 4-bit counter.
  - The top level ORs wdog_reset into the core reset request.
  - Further expiries during the pulse do not extend it.
- Without the macro:
  - bit3 reads 0 and writes are ignored.
  - The wdog_reset port and its counter do not exist.

Test Plan:
- Reset check: apply reset, then read addresses 0-4 -> all read 0x0000; interrupt=0.
- Periodic mode:
  - Stimulus: PRESCALE=3, RELOAD=4, COUNT=4, CTRL=0x7.
  - Response: expired sets 20 clocks after the CTRL write edge and again every 20 clocks; interrupt rises 1 cycle after expired.
  - Write STATUS=1 -> interrupt drops 2 cycles later.
- One-shot mode:
  - Stimulus: PRESCALE=0, COUNT=2, CTRL=0x5.
  - Response: expired after 3 clocks; CTRL reads 0x4; COUNT stays 0; no further expiries over 100 clocks.
- Collisions:
  - STATUS=1 write in the same cycle as an expiry -> expired reads 1.
  - COUNT=0x1234 write in the same cycle as a tick -> COUNT reads 0x1234.
- Mid-count reset: assert reset asynchronously while COUNT=0x0800 -> COUNT=0 and en=0 before the next clock edge.
- Watchdog (TIMER_WDOG_EN only):
  - Stimulus: CTRL=0xB, COUNT=1, PRESCALE=0.
  - Response: wdog_reset is high for exactly 16 clocks.
  - Writing CTRL=0x0 leaves bit3 reading 1.
